align_operands: RTL and testbench

//   Upstream stage of the FP add/sub datapath. Accepts two IEEE-754 single

---
 rtl/align_operands.sv | 137 +++++++++++++
 tb/tb_align_operands.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/align_operands.sv
// Operand alignment stage for the FP add/sub datapath: unpacks two singles,
// puts the larger magnitude on operand 1 and right-shifts the smaller mantissa.
module align_operands #(
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        s1,
  output logic        s2,
  output logic [23:0] m1,
  output logic [23:0] m2,
  output logic [7:0]  e1,
  output logic        sticky
);

  localparam int unsigned MW = 24;
  localparam int unsigned EW = 8;

  typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;

  state_t          r_state;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [EW-1:0]   r_diff;

  logic [EW-1:0]   w_ea_exp, w_eb_exp, w_ea_eff, w_eb_eff;
  logic [MW-1:0]   w_ma, w_mb;
  logic            w_a_big;
  logic            w_s_big, w_s_small;
  logic [EW-1:0]   w_e_big, w_e_small, w_cmp_diff;
  logic [MW-1:0]   w_m_big, w_m_small;
  logic [EW-1:0]   w_k, w_diff_nxt;
  logic [MW-1:0]   w_mask, w_m2_shr;
  logic            w_lost;

  // Unpack: denormals get hidden=0 and an effective exponent of 1.
  assign w_ea_exp = r_a[30:23];
  assign w_eb_exp = r_b[30:23];
  assign w_ea_eff = (w_ea_exp == '0) ? EW'(1) : w_ea_exp;
  assign w_eb_eff = (w_eb_exp == '0) ? EW'(1) : w_eb_exp;
  assign w_ma     = {(w_ea_exp != '0), r_a[22:0]};
  assign w_mb     = {(w_eb_exp != '0), r_b[22:0]};

  // Magnitude order; a tie keeps A as operand 1.
  assign w_a_big    = {w_ea_eff, r_a[22:0]} >= {w_eb_eff, r_b[22:0]};
  assign w_s_big    = w_a_big ? r_a[31] : r_b[31];
  assign w_s_small  = w_a_big ? r_b[31] : r_a[31];
  assign w_e_big    = w_a_big ? w_ea_eff : w_eb_eff;
  assign w_e_small  = w_a_big ? w_eb_eff : w_ea_eff;
  assign w_m_big    = w_a_big ? w_ma : w_mb;
  assign w_m_small  = w_a_big ? w_mb : w_ma;
  assign w_cmp_diff = w_e_big - w_e_small;

  // One shifter step of at most SHIFT_STEP positions.
  assign w_k        = (r_diff < EW'(SHIFT_STEP)) ? r_diff : EW'(SHIFT_STEP);
  assign w_mask     = (MW'(1) << w_k) - MW'(1);
  assign w_m2_shr   = m2 >> w_k;
  assign w_lost     = |(m2 & w_mask);
  assign w_diff_nxt = r_diff - w_k;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_diff    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      m1        <= '0;
      m2        <= '0;
      e1        <= '0;
      sticky    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            r_a      <= a;
            r_b      <= b;
            in_ready <= 1'b0;
            r_state  <= COMPARE;
          end
        end
        COMPARE: begin
          s1     <= w_s_big;
          s2     <= w_s_small;
          m1     <= w_m_big;
          e1     <= w_e_big;
          r_diff <= w_cmp_diff;
          if (w_cmp_diff == '0) begin
            m2        <= w_m_small;
            sticky    <= 1'b0;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end else if (w_cmp_diff >= EW'(MW)) begin
            // Everything falls off the end; only the sticky survives.
            m2        <= '0;
            sticky    <= |w_m_small;
            r_diff    <= '0;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end else begin
            m2      <= w_m_small;
            sticky  <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          m2     <= w_m2_shr;
          sticky <= sticky | w_lost;
          r_diff <= w_diff_nxt;
          if (w_diff_nxt == '0) begin
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_align_operands.sv
// Scoreboard bench for align_operands: a reference model predicts each result,
// which is queued at accept time and compared when out_valid rises.
module tb_align_operands;

  typedef struct {
    logic        s1;
    logic        s2;
    logic [23:0] m1;
    logic [23:0] m2;
    logic [7:0]  e1;
    logic        sticky;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic        s1, s2;
  logic [23:0] m1, m2;
  logic [7:0]  e1;
  logic        sticky;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  align_operands #(.SHIFT_STEP(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s1       (s1),
    .s2       (s2),
    .m1       (m1),
    .m2       (m2),
    .e1       (e1),
    .sticky   (sticky)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Reference: full-width shift of the smaller mantissa, latency from step count.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t        r;
    logic [7:0]  ex, ey, eb, es;
    logic [23:0] mx, my, ms;
    logic [47:0] full;
    logic        x_big;
    int          d;
    ex    = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey    = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx    = {(x[30:23] != 8'd0), x[22:0]};
    my    = {(y[30:23] != 8'd0), y[22:0]};
    x_big = ({ex, x[22:0]} >= {ey, y[22:0]});
    r.s1  = x_big ? x[31] : y[31];
    r.s2  = x_big ? y[31] : x[31];
    r.m1  = x_big ? mx : my;
    ms    = x_big ? my : mx;
    eb    = x_big ? ex : ey;
    es    = x_big ? ey : ex;
    r.e1  = eb;
    d     = int'(eb) - int'(es);
    if (d >= 24) begin
      r.m2     = 24'd0;
      r.sticky = |ms;
    end else begin
      full     = {ms, 24'd0} >> d;
      r.m2     = full[47:24];
      r.sticky = |full[23:0];
    end
    r.lat = (d == 0 || d >= 24) ? 1 : 1 + (d + 3) / 4;
    return r;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".s1"}, 64'(s1), 64'(e.s1));
    check({tag, ".s2"}, 64'(s2), 64'(e.s2));
    check({tag, ".m1"}, 64'(m1), 64'(e.m1));
    check({tag, ".m2"}, 64'(m2), 64'(e.m2));
    check({tag, ".e1"}, 64'(e1), 64'(e.e1));
    check({tag, ".sticky"}, 64'(sticky), 64'(e.sticky));
  endtask

  task automatic wait_ready(output logic ok);
    int n = 0;
    while (!in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (!ok) check("in_ready_timeout", 64'(in_ready), 64'(1));
  endtask

  // Issue one pair, check latency and result, optionally stall the hand-off.
  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input int stall);
    exp_t e;
    logic ok;
    int   lat;
    wait_ready(ok);
    if (!ok) return;
    in_valid = 1'b1;
    a        = xa;
    b        = xb;
    sb_q.push_back(model(xa, xb));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'(0), 64'(1));
      return;
    end
    e = sb_q.pop_front();
    check("latency", 64'(lat), 64'(e.lat));
    if (!out_valid) return;
    check_outputs("result", e);
    check("busy_in_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a        = $urandom;
      b        = $urandom;
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check_outputs("stall", e);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handoff_valid", 64'(out_valid), 64'(0));
    check("handoff_in_ready", 64'(in_ready), 64'(1));
    check_outputs("held", e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".in_ready"}, 64'(in_ready), 64'(0));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(0));
    check({tag, ".m1"}, 64'(m1), 64'(0));
    check({tag, ".m2"}, 64'(m2), 64'(0));
    check({tag, ".e1"}, 64'(e1), 64'(0));
    check({tag, ".signs"}, 64'({s1, s2}), 64'(0));
    check({tag, ".sticky"}, 64'(sticky), 64'(0));
  endtask

  initial begin
    logic        ok;
    logic [7:0]  xe, ye;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    // Directed operand pairs from the block's reference cases.
    run_op(32'h40400000, 32'h3F800000, 0);
    run_op(32'h3F800000, 32'hBFC00000, 0);
    run_op(32'h3F800001, 32'h4B800000, 0);
    run_op(32'h44800000, 32'h3F800001, 0);
    run_op(32'h40400000, 32'h3F800000, 5);
    run_op(32'h00000003, 32'h00000003, 0);
    run_op(32'h00400000, 32'h00800000, 2);

    // Abort in the middle of a multi-cycle shift.
    wait_ready(ok);
    if (ok) begin
      in_valid = 1'b1;
      a        = 32'h44800000;
      b        = 32'h3F800001;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_state("abort");
      reset = 1'b0;
    end
    run_op(32'h40400000, 32'h3F800000, 0);

    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 0) begin
        xe = 8'($urandom_range(0, 20));
        ye = 8'($urandom_range(0, 20));
      end else begin
        xe = 8'($urandom_range(100, 135));
        ye = 8'($urandom_range(100, 135));
      end
      run_op({1'($urandom), xe, 23'($urandom)}, {1'($urandom), ye, 23'($urandom)},
             int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
